// File: rtl/glyph_word_renderer.sv
// glyph_word_renderer: renders one character cell into the SRAM framebuffer, PIX_PER_WORD pixels
// per write handshake. The strikethrough attribute is compiled in with `define GLYPH_STRIKETHROUGH_EN.
module glyph_word_renderer #(
    parameter int unsigned        GLYPH_W      = 8,
    parameter int unsigned        GLYPH_H      = 16,
    parameter int unsigned        PIX_PER_WORD = 2,
    parameter int unsigned        COLOR_W      = 9,
    parameter int unsigned        ROW_STRIDE   = 640,
    parameter int unsigned        ADDR_W       = 20,
    parameter logic [COLOR_W-1:0] BRIGHT_MASK  = COLOR_W'(9'b100_100_100)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              start_i,
    input  logic [GLYPH_W*GLYPH_H-1:0]        shape_i,
    input  logic [COLOR_W-1:0]                fg_i,
    input  logic [COLOR_W-1:0]                bg_i,
    input  logic [ADDR_W-1:0]                 base_addr_i,
    input  logic                              eff_negative_i,
    input  logic                              eff_bright_i,
    input  logic                              eff_underline_i,
    input  logic                              eff_blink_i,
    input  logic                              eff_strike_i,
    input  logic                              cursor_i,
    input  logic                              blink_phase_i,
    output logic [ADDR_W-1:0]                 sram_addr_o,
    output logic [PIX_PER_WORD*COLOR_W-1:0]   sram_dout_o,
    output logic                              sram_den_o,
    output logic                              sram_we_n_o,
    output logic                              sram_oe_n_o,
    input  logic                              sram_done_i,
    output logic                              busy_o,
    output logic                              done_o
);

    localparam int unsigned NPIX   = GLYPH_W * GLYPH_H;
    localparam int unsigned WORD_W = PIX_PER_WORD * COLOR_W;
    localparam int unsigned XW     = $clog2(GLYPH_W + 1);
    localparam int unsigned YW     = $clog2(GLYPH_H + 1);
    localparam int unsigned PW     = $clog2(PIX_PER_WORD + 1);
    localparam int unsigned IW     = (NPIX > 1) ? $clog2(NPIX) : 1;

    typedef enum logic [1:0] {StIdle, StGather, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [XW-1:0]       x_q, x_d;
    logic [YW-1:0]       y_q, y_d;
    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic [WORD_W-1:0]   dout_q, dout_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                latch_en;

    // Cell configuration captured at start.
    logic [NPIX-1:0]     shape_q;
    logic [COLOR_W-1:0]  fg_q, bg_q;
    logic [ADDR_W-1:0]   base_q;
    logic                negative_q, bright_q, underline_q, blink_q;

    logic [COLOR_W-1:0]  fg_bright, fg_eff, bg_eff, pix;
    logic [IW-1:0]       bit_idx;
    logic                row_last;
    logic                strike_hit;
    logic [WORD_W-1:0]   pix_ext, shifted;
    logic [XW-1:0]       x0;

`ifdef GLYPH_STRIKETHROUGH_EN
    logic strike_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strike_q <= 1'b0;
        end else if (latch_en) begin
            strike_q <= eff_strike_i;
        end
    end

    assign strike_hit = strike_q && (y_q == YW'(GLYPH_H / 2));
`else
    logic unused_strike;

    assign unused_strike = eff_strike_i;
    assign strike_hit    = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shape_q     <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            base_q      <= '0;
            negative_q  <= 1'b0;
            bright_q    <= 1'b0;
            underline_q <= 1'b0;
            blink_q     <= 1'b0;
        end else if (latch_en) begin
            shape_q     <= shape_i;
            fg_q        <= fg_i;
            bg_q        <= bg_i;
            base_q      <= base_addr_i;
            negative_q  <= eff_negative_i;
            bright_q    <= eff_bright_i;
            underline_q <= eff_underline_i;
            blink_q     <= eff_blink_i;
        end
    end

    // Colour of the pixel at (x_q, y_q); cursor and blink phase are taken live.
    always_comb begin
        fg_bright = bright_q ? (fg_q | BRIGHT_MASK) : fg_q;
        fg_eff    = negative_q ? bg_q : fg_bright;
        bg_eff    = negative_q ? fg_bright : bg_q;
        if (cursor_i) begin
            fg_eff = ~fg_eff;
            bg_eff = ~bg_eff;
        end
        bit_idx  = IW'(NPIX - 1 - (32'(y_q) * GLYPH_W + 32'(x_q)));
        row_last = (y_q == YW'(GLYPH_H - 1));
        if (underline_q && row_last) begin
            pix = fg_eff;
        end else if (strike_hit) begin
            pix = fg_eff;
        end else if (blink_q && !blink_phase_i) begin
            pix = bg_eff;
        end else begin
            pix = shape_q[bit_idx] ? fg_eff : bg_eff;
        end
        // New pixel enters the top slot so the word's first pixel ends up least significant.
        pix_ext = WORD_W'(pix);
        shifted = (sh_q >> COLOR_W) | (pix_ext << (WORD_W - COLOR_W));
        x0      = x_q - XW'(PIX_PER_WORD - 1);
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        pcnt_d      = pcnt_q;
        sh_d        = sh_q;
        dout_d      = dout_q;
        addr_d      = addr_q;
        latch_en    = 1'b0;
        sram_den_o  = 1'b0;
        sram_we_n_o = 1'b1;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                done_o = (state_q == StDone);
                if (start_i) begin
                    latch_en = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    pcnt_d   = '0;
                    state_d  = StGather;
                end
            end
            StGather: begin
                busy_o = 1'b1;
                sh_d   = shifted;
                x_d    = x_q + XW'(1);
                if (pcnt_q == PW'(PIX_PER_WORD - 1)) begin
                    pcnt_d  = '0;
                    dout_d  = shifted;
                    addr_d  = base_q
                            + ADDR_W'((32'(y_q) * ROW_STRIDE + 32'(x0)) / PIX_PER_WORD);
                    state_d = StWrite;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            StWrite: begin
                busy_o      = 1'b1;
                sram_den_o  = 1'b1;
                sram_we_n_o = 1'b0;
                if (sram_done_i) begin
                    state_d = StGather;
                    if (x_q == XW'(GLYPH_W)) begin
                        if (row_last) begin
                            state_d = StDone;
                        end else begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            pcnt_q  <= '0;
            sh_q    <= '0;
            dout_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pcnt_q  <= pcnt_d;
            sh_q    <= sh_d;
            dout_q  <= dout_d;
            addr_q  <= addr_d;
        end
    end

    assign sram_addr_o = addr_q;
    assign sram_dout_o = dout_q;
    assign sram_oe_n_o = 1'b1;

endmodule

// File: tb/tb_glyph_word_renderer.sv
// Randomised bench for glyph_word_renderer against a per-pixel reference model of the cell.
// Build with +define+GLYPH_STRIKETHROUGH_EN to exercise the strikethrough attribute.
module tb_glyph_word_renderer;

    localparam int GW     = 8;
    localparam int GH     = 16;
    localparam int PPW    = 2;
    localparam int CW     = 9;
    localparam int STRIDE = 640;
    localparam int AW     = 20;
    localparam int NPIX   = GW * GH;
    localparam int WW     = PPW * CW;
    localparam int NWORDS = NPIX / PPW;
    localparam logic [CW-1:0] BMASK = 9'b100_100_100;

    logic            clk, rst_n, start;
    logic [NPIX-1:0] shape;
    logic [CW-1:0]   fg, bg;
    logic [AW-1:0]   base_addr;
    logic            eff_negative, eff_bright, eff_underline, eff_blink, eff_strike;
    logic            cursor, blink_phase;
    logic [AW-1:0]   sram_addr;
    logic [WW-1:0]   sram_dout;
    logic            sram_den, sram_we_n, sram_oe_n, sram_done;
    logic            busy, done;

    glyph_word_renderer dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .shape_i        (shape),
        .fg_i           (fg),
        .bg_i           (bg),
        .base_addr_i    (base_addr),
        .eff_negative_i (eff_negative),
        .eff_bright_i   (eff_bright),
        .eff_underline_i(eff_underline),
        .eff_blink_i    (eff_blink),
        .eff_strike_i   (eff_strike),
        .cursor_i       (cursor),
        .blink_phase_i  (blink_phase),
        .sram_addr_o    (sram_addr),
        .sram_dout_o    (sram_dout),
        .sram_den_o     (sram_den),
        .sram_we_n_o    (sram_we_n),
        .sram_oe_n_o    (sram_oe_n),
        .sram_done_i    (sram_done),
        .busy_o         (busy),
        .done_o         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Cell description used by both the stimulus and the model.
    logic [NPIX-1:0] c_shape;
    logic [CW-1:0]   c_fg, c_bg;
    logic [AW-1:0]   c_base;
    logic            c_neg, c_bri, c_und, c_bli, c_str, c_cur, c_bph;

    logic [AW-1:0] q_addr[$];
    logic [WW-1:0] q_data[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cell();
        c_shape = '0; c_fg = '0; c_bg = '0; c_base = '0;
        c_neg = 0; c_bri = 0; c_und = 0; c_bli = 0; c_str = 0; c_cur = 0; c_bph = 1;
    endtask

    // Expected write stream: every pixel coloured from the attribute rules, packed per word.
    task automatic build_model();
        logic [CW-1:0] f, b, col;
        logic [WW-1:0] word;
        logic          strike_on;
        int            idx;
        q_addr.delete();
        q_data.delete();
        word = '0;
        f = c_bri ? (c_fg | BMASK) : c_fg;
        b = c_bg;
        if (c_neg) begin col = f; f = b; b = col; end
        if (c_cur) begin f = ~f; b = ~b; end
`ifdef GLYPH_STRIKETHROUGH_EN
        strike_on = c_str;
`else
        strike_on = 1'b0;
`endif
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                idx = NPIX - 1 - (y * GW + x);
                if (c_und && y == GH - 1)       col = f;
                else if (strike_on && y == GH / 2) col = f;
                else if (c_bli && !c_bph)       col = b;
                else                            col = c_shape[idx] ? f : b;
                word[(x % PPW) * CW +: CW] = col;
                if (x % PPW == PPW - 1) begin
                    q_addr.push_back(AW'(32'(c_base) + (y * STRIDE + x - (PPW - 1)) / PPW));
                    q_data.push_back(word);
                end
            end
        end
    endtask

    task automatic drive_cell();
        shape = c_shape; fg = c_fg; bg = c_bg; base_addr = c_base;
        eff_negative = c_neg; eff_bright = c_bri; eff_underline = c_und;
        eff_blink = c_bli; eff_strike = c_str; cursor = c_cur; blink_phase = c_bph;
    endtask

    // Render one cell; the arbiter holds off sram_done for 'waits' cycles per word.
    // abort_at > 0 pulses reset during that write and abandons the cell.
    task automatic run_cell(input int waits, input int abort_at, input bit noise);
        int            cyc, wcnt, nwr, budget;
        logic [AW-1:0] hold_a;
        logic [WW-1:0] hold_d;
        build_model();
        budget = NWORDS * (PPW + 2 + waits) + 20;
        @(negedge clk);
        drive_cell();
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        wcnt = 0;
        nwr = 0;
        hold_a = '0;
        hold_d = '0;
        while (!done && cyc < budget) begin
            start = 1'b0;
            sram_done = 1'b0;
            if (sram_den) begin
                if (wcnt == 0) begin
                    nwr++;
                    check_eq("we_n_in_write", 64'(sram_we_n), 64'd0);
                    if (q_addr.size() == 0) begin
                        check_eq("extra_write", 64'(nwr), 64'(NWORDS));
                    end else begin
                        check_eq("addr", 64'(sram_addr), 64'(q_addr[0]));
                        check_eq("dout", 64'(sram_dout), 64'(q_data[0]));
                    end
                    hold_a = sram_addr;
                    hold_d = sram_dout;
                    if (abort_at == nwr) begin
                        #2 rst_n = 1'b0;
                        #1;
                        check_eq("rst_we_n", 64'(sram_we_n), 64'd1);
                        check_eq("rst_den", 64'(sram_den), 64'd0);
                        check_eq("rst_done", 64'(done), 64'd0);
                        check_eq("rst_busy", 64'(busy), 64'd0);
                        check_eq("rst_addr", 64'(sram_addr), 64'd0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        repeat (3) @(negedge clk);
                        check_eq("idle_after_rst_den", 64'(sram_den), 64'd0);
                        check_eq("idle_after_rst_busy", 64'(busy), 64'd0);
                        return;
                    end
                end else begin
                    check_eq("addr_hold", 64'(sram_addr), 64'(hold_a));
                    check_eq("dout_hold", 64'(sram_dout), 64'(hold_d));
                end
                if (wcnt == waits) begin
                    sram_done = 1'b1;
                    wcnt = 0;
                    if (q_addr.size() > 0) begin
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                    end
                end else begin
                    wcnt++;
                end
            end else if (noise) begin
                // Stray handshakes and restart attempts while busy must have no effect.
                sram_done = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) begin
                    start = 1'b1;
                    shape = {$urandom, $urandom, $urandom, $urandom};
                    fg = CW'($urandom);
                    base_addr = AW'($urandom);
                end
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        sram_done = 1'b0;
        check_eq("done", 64'(done), 64'd1);
        check_eq("busy_at_done", 64'(busy), 64'd0);
        check_eq("cycles", 64'(cyc), 64'(NWORDS * (PPW + 1 + waits) + 1));
        check_eq("nwrites", 64'(nwr), 64'(NWORDS));
        check_eq("writes_left", 64'(q_addr.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sram_done = 1'b0;
        clear_cell();
        drive_cell();
        repeat (3) @(negedge clk);
        check_eq("reset_den", 64'(sram_den), 64'd0);
        check_eq("reset_we_n", 64'(sram_we_n), 64'd1);
        check_eq("reset_oe_n", 64'(sram_oe_n), 64'd1);
        check_eq("reset_addr", 64'(sram_addr), 64'd0);
        check_eq("reset_dout", 64'(sram_dout), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        rst_n = 1'b1;

        // All-ones glyph, zero-wait arbiter: 193 cycles, every word all-foreground.
        clear_cell();
        c_shape = '1; c_fg = 9'h1FF; c_base = 20'h01234;
        run_cell(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("done_holds", 64'(done), 64'd1);

        // Underline on an empty glyph.
        clear_cell();
        c_und = 1; c_fg = 9'h0A5; c_bg = 9'h003; c_base = 20'h00500;
        run_cell(0, 0, 1'b0);

        // Bright, negative and cursor together.
        clear_cell();
        c_neg = 1; c_bri = 1; c_cur = 1; c_fg = 9'h012; c_bg = 9'h0C0; c_base = 20'h10000;
        run_cell(0, 0, 1'b0);

        // Slow arbiter: five wait cycles per word.
        clear_cell();
        c_shape = {$urandom, $urandom, $urandom, $urandom};
        c_fg = 9'h155; c_bg = 9'h0AA; c_base = 20'h08000;
        run_cell(5, 0, 1'b1);

        // Reset during the 10th write, then the same cell rendered from scratch.
        clear_cell();
        c_shape = {$urandom, $urandom, $urandom, $urandom};
        c_fg = 9'h1C3; c_bg = 9'h024; c_base = 20'h02000;
        run_cell(2, 10, 1'b0);
        run_cell(0, 0, 1'b0);

        // Strikethrough row on an empty glyph.
        clear_cell();
        c_str = 1; c_fg = 9'h1F0; c_bg = 9'h00F; c_base = 20'h03000;
        run_cell(0, 0, 1'b0);

        // Blink-off phase forces background.
        clear_cell();
        c_shape = '1; c_bli = 1; c_bph = 0; c_fg = 9'h111; c_bg = 9'h0EE; c_base = 20'h04000;
        run_cell(1, 0, 1'b0);

        // Randomised cells, including one whose addresses wrap past the top of SRAM.
        for (int n = 0; n < 6; n++) begin
            c_shape = {$urandom, $urandom, $urandom, $urandom};
            c_fg  = CW'($urandom);
            c_bg  = CW'($urandom);
            c_base = (n == 0) ? 20'hFFFFE : AW'($urandom);
            c_neg = 1'($urandom_range(0, 1));
            c_bri = 1'($urandom_range(0, 1));
            c_und = 1'($urandom_range(0, 1));
            c_bli = 1'($urandom_range(0, 1));
            c_str = 1'($urandom_range(0, 1));
            c_cur = 1'($urandom_range(0, 1));
            c_bph = 1'($urandom_range(0, 1));
            run_cell($urandom_range(0, 3), 0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
